// File: rtl/interboard_pkg.sv
// Shared types for the inter-board transmitter: message layout, beat encodings, FSM states.
package interboard_pkg;

    localparam int unsigned TYPE_W = 3;
    localparam int unsigned NUM_W  = 5;
    localparam int unsigned MSG_W  = TYPE_W + NUM_W;
    localparam int unsigned BEAT_W = 6;

    // Message-type codes
    localparam logic [TYPE_W-1:0] MT_NOP    = 3'd0;
    localparam logic [TYPE_W-1:0] MT_PING   = 3'd1;
    localparam logic [TYPE_W-1:0] MT_CMD    = 3'd2;
    localparam logic [TYPE_W-1:0] MT_STATUS = 3'd3;
    localparam logic [TYPE_W-1:0] MT_DATA   = 3'd4;
    localparam logic [TYPE_W-1:0] MT_ERROR  = 3'd7;

    // Queue entry as stored in the FIFO
    typedef struct packed {
        logic [TYPE_W-1:0] msg_type;
        logic [NUM_W-1:0]  number;
    } msg_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP0 = 3'd1,
        ST_REQ0   = 3'd2,
        ST_REL0   = 3'd3,
        ST_SETUP1 = 3'd4,
        ST_REQ1   = 3'd5,
        ST_REL1   = 3'd6
    } state_e;

    // First beat carries the type; bit 5 clear marks it as beat0
    function automatic logic [BEAT_W-1:0] beat0(input msg_t m);
        return {3'b000, m.msg_type};
    endfunction

    // Second beat carries the number; bit 5 set marks it as beat1
    function automatic logic [BEAT_W-1:0] beat1(input msg_t m);
        return {1'b1, m.number};
    endfunction

endpackage

// File: rtl/msg_fifo.sv
// Message queue: DEPTH entries of 8 bits, head readable without popping.
module msg_fifo
    import interboard_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [MSG_W-1:0] wdata,
    input  logic             pop,
    output logic [MSG_W-1:0] rdata_c,
    output logic             empty_c,
    output logic             full_c,
    output logic             empty_next_c,
    output logic             ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [MSG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, ready_d;
    logic             push_ok, pop_ok;

    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign empty_c = (count_q == '0);
    assign rdata_c = mem_q[rd_ptr_q];
    assign ready   = ready_q;

    // Pointer/count update; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        push_ok  = push && !full_c;
        pop_ok   = pop && !empty_c;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: ;
        endcase
        ready_d      = (count_d != CNT_W'(DEPTH));
        empty_next_c = (count_d == '0);
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/interboard_tx.sv
// Sends queued messages to a peer board as two beats over a four-phase handshake.
module interboard_tx
    import interboard_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_en,
    input  logic [TYPE_W-1:0] ctrl_msg_type,
    input  logic [NUM_W-1:0]  ctrl_number,
    input  logic              Ack_in,
    output logic              inter_ready,
    output logic              Request_out,
    output logic [BEAT_W-1:0] inter_data_out,
    output logic              busy,
    output logic              tx_done,
    output logic              tx_timeout,
    output logic              overflow
);

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e            state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [BEAT_W-1:0] data_q, data_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tmo_pulse_q, tmo_pulse_d;
    logic              ovf_q, ovf_d;
    logic              ack_meta_q, ack_s_q;

    logic              pop_c;
    logic              in_wait_c, tmo_hit_c;
    logic [MSG_W-1:0]  fifo_rdata_c;
    logic              fifo_empty_c, fifo_full_c, fifo_empty_next_c, fifo_ready;
    msg_t              head_c;

    msg_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (ctrl_en),
        .wdata        ({ctrl_msg_type, ctrl_number}),
        .pop          (pop_c),
        .rdata_c      (fifo_rdata_c),
        .empty_c      (fifo_empty_c),
        .full_c       (fifo_full_c),
        .empty_next_c (fifo_empty_next_c),
        .ready        (fifo_ready)
    );

    assign head_c = msg_t'(fifo_rdata_c);

    // Two-flop synchronizer for the peer acknowledge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= Ack_in;
            ack_s_q    <= ack_meta_q;
        end
    end

    // Next state, registered outputs and timeout counter
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        req_d       = 1'b0;
        pop_c       = 1'b0;
        done_d      = 1'b0;
        tmo_pulse_d = 1'b0;
        in_wait_c   = (state_q inside {ST_REQ0, ST_REL0, ST_REQ1, ST_REL1});
        tmo_hit_c   = in_wait_c && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

        if (tmo_hit_c) begin
            state_d     = ST_IDLE;
            pop_c       = 1'b1;
            tmo_pulse_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE:   if (!fifo_empty_c && !ack_s_q) state_d = ST_SETUP0;
                ST_SETUP0: begin
                    data_d  = beat0(head_c);
                    state_d = ST_REQ0;
                end
                ST_REQ0:   if (ack_s_q) state_d = ST_REL0; else req_d = 1'b1;
                ST_REL0:   if (!ack_s_q) state_d = ST_SETUP1;
                ST_SETUP1: begin
                    data_d  = beat1(head_c);
                    state_d = ST_REQ1;
                end
                ST_REQ1:   if (ack_s_q) state_d = ST_REL1; else req_d = 1'b1;
                ST_REL1: begin
                    if (!ack_s_q) begin
                        pop_c   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default:   state_d = ST_IDLE;
            endcase
        end

        // Counter restarts on every state entry and only runs while waiting on the peer
        tmo_d  = (state_d != state_q || !in_wait_c) ? '0 : tmo_q + TMO_W'(1);
        ovf_d  = ctrl_en && fifo_full_c;
        busy_d = (state_d != ST_IDLE) || !fifo_empty_next_c;
    end

    // FSM and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            data_q      <= '0;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tmo_pulse_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            data_q      <= data_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tmo_pulse_q <= tmo_pulse_d;
            ovf_q       <= ovf_d;
        end
    end

    assign inter_ready    = fifo_ready;
    assign Request_out    = req_q;
    assign inter_data_out = data_q;
    assign busy           = busy_q;
    assign tx_done        = done_q;
    assign tx_timeout     = tmo_pulse_q;
    assign overflow       = ovf_q;

endmodule
